// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
// Bundle of the three buses around the byte-wide RAM/IO arbiter:
//   IF side  : if_req, if_addr, if_clear  -> ; <- if_data, if_done
//   MEM side : mem_req, mem_we, mem_len, mem_addr, mem_wdata -> ;
//              <- mem_rdata, mem_done
//   RAM side : ram_din -> ; <- ram_dout, ram_a, ram_wr
// Modport slave is the arbiter's view, modport master is the requester/RAM
// environment's view.
// -----------------------------------------------------------------------------
interface mem_arbiter_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  if_req;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic                  if_clear;
    logic [31:0]           if_data;
    logic                  if_done;

    logic                  mem_req;
    logic                  mem_we;
    logic [1:0]            mem_len;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;
    logic [31:0]           mem_rdata;
    logic                  mem_done;

    logic [7:0]            ram_din;
    logic [7:0]            ram_dout;
    logic [ADDR_WIDTH-1:0] ram_a;
    logic                  ram_wr;

    modport slave (
        input  if_req, if_addr, if_clear,
        output if_data, if_done,
        input  mem_req, mem_we, mem_len, mem_addr, mem_wdata,
        output mem_rdata, mem_done,
        input  ram_din,
        output ram_dout, ram_a, ram_wr
    );

    modport master (
        output if_req, if_addr, if_clear,
        input  if_data, if_done,
        output mem_req, mem_we, mem_len, mem_addr, mem_wdata,
        input  mem_rdata, mem_done,
        output ram_din,
        input  ram_dout, ram_a, ram_wr
    );
endinterface

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Single-port controller for the byte-wide RAM/IO bus shared by instruction
// fetch (IF) and the MEM stage. Multi-byte requests are serialised into
// consecutive byte cycles; read bytes are assembled little-endian. MEM has
// priority over IF. Each accepted request ends with a one-cycle done pulse.
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous active-low reset
//   rdy            global ready; low freezes every register and masks ram_wr
//   io_buffer_full (only with IO_FULL_STALL_EN) stalls store bytes whose
//                  address has bits [17:16] = 2'b11
//   bus            mem_arbiter_if.slave (IF, MEM and RAM buses)
//
// Optional feature macro: IO_FULL_STALL_EN (undefined: writes never stall).
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rdy,
`ifdef IO_FULL_STALL_EN
    input  logic          io_buffer_full,
`endif
    mem_arbiter_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_IF_RD  = 3'd1,
        ST_MEM_RD = 3'd2,
        ST_MEM_WR = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_t                state_r;
    logic [2:0]            cnt_r;      // read: cycles spent in state; write: byte index on the bus
    logic [1:0]            last_r;     // index of the final byte (N-1)
    logic [31:0]           buf_r;      // partially assembled read word
    logic [31:0]           wdata_r;    // store bytes not yet driven, next one in [7:0]
    logic [ADDR_WIDTH-1:0] ram_a_r;
    logic [7:0]            ram_dout_r;
    logic                  ram_wr_r;
    logic [31:0]           if_data_r;
    logic                  if_done_r;
    logic [31:0]           mem_rdata_r;
    logic                  mem_done_r;

    logic [31:0]           word_s;
    logic [1:0]            cap_idx_s;
    logic                  stall_s;

    // Map mem_len to the index of the last byte; the reserved code acts as word.
    function automatic logic [1:0] last_idx(input logic [1:0] len);
        logic [1:0] idx;
        case (len)
            2'd0:    idx = 2'd0;
            2'd1:    idx = 2'd1;
            default: idx = 2'd3;
        endcase
        return idx;
    endfunction

    // Merge the byte now on ram_din into the assembled word. In read cycle
    // cnt_r+1 the bus carries the byte addressed one cycle earlier.
    always_comb begin
        word_s    = buf_r;
        cap_idx_s = 2'd0;
        if (cnt_r != 3'd0) begin
            cap_idx_s = 2'(cnt_r - 3'd1);
            word_s[{cap_idx_s, 3'b000} +: 8] = bus.ram_din;
        end else begin
            cap_idx_s = 2'd0;
        end
    end

    // Decide whether the current store byte targets the full IO buffer.
    always_comb begin
`ifdef IO_FULL_STALL_EN
        if ((state_r == ST_MEM_WR) && io_buffer_full && (ram_a_r[17:16] == 2'b11)) begin
            stall_s = 1'b1;
        end else begin
            stall_s = 1'b0;
        end
`else
        stall_s = 1'b0;
`endif
    end

    assign bus.ram_wr    = ram_wr_r & rdy & ~stall_s;
    assign bus.ram_a     = ram_a_r;
    assign bus.ram_dout  = ram_dout_r;
    assign bus.if_data   = if_data_r;
    assign bus.if_done   = if_done_r;
    assign bus.mem_rdata = mem_rdata_r;
    assign bus.mem_done  = mem_done_r;

    // Arbitration FSM with all bus-side outputs registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 3'd0;
            last_r      <= 2'd0;
            buf_r       <= 32'd0;
            wdata_r     <= 32'd0;
            ram_a_r     <= '0;
            ram_dout_r  <= 8'd0;
            ram_wr_r    <= 1'b0;
            if_data_r   <= 32'd0;
            if_done_r   <= 1'b0;
            mem_rdata_r <= 32'd0;
            mem_done_r  <= 1'b0;
        end else if (rdy) begin
            case (state_r)
                ST_IDLE: begin
                    cnt_r <= 3'd0;
                    buf_r <= 32'd0;
                    if (bus.mem_req) begin
                        state_r    <= bus.mem_we ? ST_MEM_WR : ST_MEM_RD;
                        last_r     <= last_idx(bus.mem_len);
                        ram_a_r    <= bus.mem_addr;
                        ram_dout_r <= bus.mem_wdata[7:0];
                        wdata_r    <= {8'h00, bus.mem_wdata[31:8]};
                        ram_wr_r   <= bus.mem_we;
                    end else if (bus.if_req && !bus.if_clear) begin
                        state_r  <= ST_IF_RD;
                        last_r   <= 2'd3;
                        ram_a_r  <= bus.if_addr;
                        ram_wr_r <= 1'b0;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_IF_RD, ST_MEM_RD: begin
                    if ((state_r == ST_IF_RD) && bus.if_clear) begin
                        // Branch redirect: drop the partial word, no done pulse.
                        state_r <= ST_IDLE;
                        cnt_r   <= 3'd0;
                    end else begin
                        if (cnt_r != 3'd0) begin
                            buf_r <= word_s;
                        end
                        if (cnt_r < {1'b0, last_r}) begin
                            ram_a_r <= ram_a_r + ADDR_ONE;
                        end
                        if (cnt_r == ({1'b0, last_r} + 3'd1)) begin
                            state_r <= ST_DONE;
                            cnt_r   <= 3'd0;
                            if (state_r == ST_IF_RD) begin
                                if_data_r <= word_s;
                                if_done_r <= 1'b1;
                            end else begin
                                mem_rdata_r <= word_s;
                                mem_done_r  <= 1'b1;
                            end
                        end else begin
                            cnt_r <= cnt_r + 3'd1;
                        end
                    end
                end
                ST_MEM_WR: begin
                    if (stall_s) begin
                        state_r <= ST_MEM_WR;
                    end else if (cnt_r < {1'b0, last_r}) begin
                        ram_a_r    <= ram_a_r + ADDR_ONE;
                        ram_dout_r <= wdata_r[7:0];
                        wdata_r    <= {8'h00, wdata_r[31:8]};
                        cnt_r      <= cnt_r + 3'd1;
                    end else begin
                        ram_wr_r   <= 1'b0;
                        cnt_r      <= 3'd0;
                        state_r    <= ST_DONE;
                        mem_done_r <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if_done_r  <= 1'b0;
                    mem_done_r <= 1'b0;
                    state_r    <= ST_IDLE;
                end
                default: begin
                    ram_wr_r <= 1'b0;
                    state_r  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Self-checking bench for mem_arbiter. A byte-addressed RAM model (associative
// array plus an address-derived fill pattern) answers the RAM bus. Each
// transaction's expected latency, read word and written bytes are computed
// from the request alone: N bytes, read done after N+2 cycles, store done
// after N+1 cycles, plus any cycles spent with rdy low.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;
    localparam int AW = 32;

    logic clk = 1'b0;
    logic rst;
    logic rdy;
`ifdef IO_FULL_STALL_EN
    logic io_buffer_full;
`endif

    int checks_n = 0;
    int fails_n  = 0;

    mem_arbiter_if #(.ADDR_WIDTH(AW)) bus ();

    mem_arbiter #(.ADDR_WIDTH(AW)) dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
`ifdef IO_FULL_STALL_EN
        .io_buffer_full (io_buffer_full),
`endif
        .bus            (bus)
    );

    always #5 clk = ~clk;

    bit [7:0] ram_m [bit [31:0]];

    function automatic bit [7:0] rd_byte(input bit [31:0] a);
        if (ram_m.exists(a)) return ram_m[a];
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
    endfunction

    // RAM model: one-cycle read latency, shares the global ready.
    always @(posedge clk) begin
        if (rdy) begin
            bus.ram_din <= rd_byte(bus.ram_a);
            if (bus.ram_wr) ram_m[bus.ram_a] = bus.ram_dout;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_n++;
        if (got !== exp) begin
            fails_n++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int nbytes(input bit is_mem, input logic [1:0] len);
        if (!is_mem) return 4;
        if (len == 2'd0) return 1;
        if (len == 2'd1) return 2;
        return 4;
    endfunction

    // One request, entered and left at a negedge while the DUT idles.
    task automatic do_txn(input bit is_mem, input bit we, input logic [1:0] len,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input int frz_at, input int frz_len);
        int n, exp_c, done_c;
        bit wr;
        logic [31:0] exp_d;
        bit [7:0] after_b;
        logic d, od;
        n     = nbytes(is_mem, len);
        wr    = is_mem && we;
        exp_d = 32'd0;
        for (int k = 0; k < n; k++) exp_d |= 32'(rd_byte(addr + 32'(k))) << (8 * k);
        after_b = rd_byte(addr + 32'(n));
        exp_c   = (wr ? n + 1 : n + 2) + frz_len;
        if (is_mem) begin
            bus.mem_req = 1'b1; bus.mem_we = we; bus.mem_len = len;
            bus.mem_addr = addr; bus.mem_wdata = wdata;
        end else begin
            bus.if_req = 1'b1; bus.if_addr = addr;
        end
        @(posedge clk);
        #1;
        // Request fields change after acceptance and must be ignored.
        if (is_mem) begin
            bus.mem_req = 1'b0; bus.mem_we = ~we; bus.mem_len = ~len;
            bus.mem_addr = $urandom; bus.mem_wdata = $urandom;
        end else begin
            bus.if_req = 1'b0; bus.if_addr = $urandom;
        end
        done_c = 0;
        for (int c = 1; c <= 30 && done_c == 0; c++) begin
            @(negedge clk);
            d  = is_mem ? bus.mem_done : bus.if_done;
            od = is_mem ? bus.if_done : bus.mem_done;
            chk("other_done", 32'(od), 32'd0);
            if (d) begin
                done_c = c;
                chk("latency", 32'(c), 32'(exp_c));
                if (!wr) chk("rdata", is_mem ? bus.mem_rdata : bus.if_data, exp_d);
            end else if (frz_len == 0 && c <= n) begin
                chk("ram_a", bus.ram_a, addr + 32'(c - 1));
                chk("ram_wr", 32'(bus.ram_wr), 32'(wr));
                if (wr) chk("ram_dout", 32'(bus.ram_dout), (wdata >> (8 * (c - 1))) & 32'hFF);
            end
            rdy = !(c >= frz_at && c < frz_at + frz_len);
            #1;
            if (!rdy) chk("wr_frozen", 32'(bus.ram_wr), 32'd0);
        end
        rdy = 1'b1;
        if (done_c == 0) chk("done_timeout", 32'd0, 32'd1);
        @(negedge clk);
        chk("done_pulse", 32'(is_mem ? bus.mem_done : bus.if_done), 32'd0);
        if (wr) begin
            for (int k = 0; k < n; k++)
                chk("wbyte", 32'(rd_byte(addr + 32'(k))), (wdata >> (8 * k)) & 32'hFF);
            chk("wbound", 32'(rd_byte(addr + 32'(n))), 32'(after_b));
        end
    endtask

    bit          r_m, r_w;
    logic [1:0]  r_l;
    logic [31:0] r_a;
    int          r_fa, r_fl;

    initial begin
        rst = 1'b0; rdy = 1'b1;
        bus.if_req = 1'b0; bus.if_addr = '0; bus.if_clear = 1'b0;
        bus.mem_req = 1'b0; bus.mem_we = 1'b0; bus.mem_len = 2'd0;
        bus.mem_addr = '0; bus.mem_wdata = 32'd0;
`ifdef IO_FULL_STALL_EN
        io_buffer_full = 1'b0;
`endif
        #1;
        chk("rst_ram_a", bus.ram_a, 32'd0);
        chk("rst_ram_dout", 32'(bus.ram_dout), 32'd0);
        chk("rst_ram_wr", 32'(bus.ram_wr), 32'd0);
        chk("rst_if_data", bus.if_data, 32'd0);
        chk("rst_if_done", 32'(bus.if_done), 32'd0);
        chk("rst_mem_rdata", bus.mem_rdata, 32'd0);
        chk("rst_mem_done", 32'(bus.mem_done), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Instruction word fetch with a known encoding.
        ram_m[32'h100] = 8'h13; ram_m[32'h101] = 8'h05;
        ram_m[32'h102] = 8'h10; ram_m[32'h103] = 8'h00;
        do_txn(1'b0, 1'b0, 2'd0, 32'h100, 32'd0, 1, 0);
        chk("if_word", bus.if_data, 32'h0010_0513);

        // Simultaneous requests: MEM first, IF taken right after DONE.
        bus.if_req = 1'b1; bus.if_addr = 32'h40;
        do_txn(1'b1, 1'b0, 2'd1, 32'h2002, 32'd0, 1, 0);
        chk("half_zext", bus.mem_rdata >> 16, 32'd0);
        do_txn(1'b0, 1'b0, 2'd0, 32'h40, 32'd0, 1, 0);

        // Store word.
        do_txn(1'b1, 1'b1, 2'd2, 32'h3FFFC, 32'hDEAD_BEEF, 1, 0);

        // Fetch aborted in its third cycle, then a new fetch.
        bus.if_req = 1'b1; bus.if_addr = 32'h400;
        @(posedge clk);
        #1 bus.if_req = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            chk("clr_no_done", 32'(bus.if_done), 32'd0);
        end
        bus.if_clear = 1'b1;
        @(negedge clk);
        chk("clr_no_done", 32'(bus.if_done), 32'd0);
        bus.if_clear = 1'b0;
        do_txn(1'b0, 1'b0, 2'd0, 32'h200, 32'd0, 1, 0);

        // rdy low for three cycles during a read and during a store.
        do_txn(1'b0, 1'b0, 2'd0, 32'h500, 32'd0, 2, 3);
        do_txn(1'b1, 1'b1, 2'd2, 32'h600, 32'hA5C3_1E77, 2, 3);

        // Reset in the middle of a store.
        bus.mem_req = 1'b1; bus.mem_we = 1'b1; bus.mem_len = 2'd2;
        bus.mem_addr = 32'h3FFFC; bus.mem_wdata = 32'h1234_5678;
        @(posedge clk);
        #1 bus.mem_req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rst_wr", 32'(bus.ram_wr), 32'd0);
        chk("mid_rst_a", bus.ram_a, 32'd0);
        chk("mid_rst_dout", 32'(bus.ram_dout), 32'd0);
        chk("mid_rst_if_data", bus.if_data, 32'd0);
        chk("mid_rst_rdata", bus.mem_rdata, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("post_rst_done", 32'(bus.mem_done | bus.if_done), 32'd0);
            chk("post_rst_wr", 32'(bus.ram_wr), 32'd0);
        end

`ifdef IO_FULL_STALL_EN
        // IO byte store held off for two cycles.
        bus.mem_req = 1'b1; bus.mem_we = 1'b1; bus.mem_len = 2'd0;
        bus.mem_addr = 32'h0003_0010; bus.mem_wdata = 32'h0000_005A;
        @(posedge clk);
        #1 bus.mem_req = 1'b0; io_buffer_full = 1'b1;
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            chk("io_stall_wr", 32'(bus.ram_wr), 32'd0);
        end
        @(posedge clk);
        #1 io_buffer_full = 1'b0;
        @(negedge clk);
        chk("io_issue_wr", 32'(bus.ram_wr), 32'd1);
        chk("io_early_done", 32'(bus.mem_done), 32'd0);
        @(negedge clk);
        chk("io_done", 32'(bus.mem_done), 32'd1);
        @(negedge clk);
        chk("io_byte", 32'(rd_byte(32'h0003_0010)), 32'h5A);
`endif

        // Randomised traffic, including address wrap and rdy freezes.
        for (int t = 0; t < 40; t++) begin
            r_m = 1'($urandom_range(0, 1));
            r_w = 1'($urandom_range(0, 1));
            r_l = 2'($urandom_range(0, 3));
            r_a = $urandom;
            if ($urandom_range(0, 3) == 0) r_a = 32'hFFFF_FFFE;
            r_fa = 1; r_fl = 0;
            if ($urandom_range(0, 3) == 0) begin
                r_fl = $urandom_range(1, 3);
                r_fa = $urandom_range(1, nbytes(r_m, r_l));
            end
            do_txn(r_m, r_w, r_l, r_a, $urandom, r_fa, r_fl);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks_n, fails_n);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Single-port controller for the byte-wide RAM/IO bus, shared by instruction fetch (IF) and the MEM stage.
- Serialises multi-byte requests into consecutive byte cycles and assembles read data little-endian.
- Returns a one-cycle done pulse to the winning requester; IF and MEM hold their pipeline registers (including MEM_WB input) until done.
- MEM has priority over IF.

Parameters:
- ADDR_WIDTH, 32, width of request and RAM addresses.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- rdy  input  1  global ready; low freezes all state.
- if_req  input  1  IF fetch request (always a 4-byte read).
- if_addr  input  ADDR_WIDTH  fetch address.
- if_clear  input  1  abort the in-flight fetch (branch redirect).
- if_data  output  32  fetched word, valid while if_done=1.
- if_done  output  1  one-cycle fetch completion pulse.
- mem_req  input  1  MEM load/store request.
- mem_we  input  1  1=store, 0=load.
- mem_len  input  2  0=byte, 1=half, 2=word; 3 reserved, treated as word.
- mem_addr  input  ADDR_WIDTH  access address.
- mem_wdata  input  32  store data, low bytes used.
- mem_rdata  output  32  load data, zero-extended, valid while mem_done=1.
- mem_done  output  1  one-cycle MEM completion pulse.
- ram_din  input  8  RAM read byte; valid the cycle after its address.
- ram_dout  output  8  RAM write byte.
- ram_a  output  ADDR_WIDTH  RAM byte address.
- ram_wr  output  1  1=write this cycle.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, byte counter=0, ram_a=0, ram_dout=0, ram_wr=0, if_data=0, mem_rdata=0, if_done=0, mem_done=0.
- rdy=0: all registers hold, and ram_wr is forced to 0 combinationally.
- All outputs are registered.
- FSM states: IDLE, IF_RD, MEM_RD, MEM_WR, DONE.
- IDLE:
  - mem_req=1 → MEM_RD or MEM_WR; MEM wins when both requests are high.
  - Otherwise if_req=1 and if_clear=0 → IF_RD.
  - Address, length and data are latched at this edge. Later changes to the request inputs are ignored.
- N = 1/2/4 bytes from mem_len; IF always uses N=4.
- Reads:
  - Byte k address (base+k) is driven on ram_a in cycle k+1 after the accept edge, k=0..N-1.
  - ram_din is captured one cycle later into bits [8k+7:8k].
  - done rises in cycle N+2, with if_data/mem_rdata stable during that cycle.
  - Word read: accept edge to done = 6 cycles.
- Writes:
  - In cycles 1..N after accept: ram_wr=1, ram_a=base+k, ram_dout=wdata[8k+7:8k].
  - mem_done rises in cycle N+1 (word = 5 cycles).
- DONE lasts exactly one cycle: the done pulse is high and requests are ignored. Next state is IDLE.
- Requesters must drop or replace req on the cycle after done. A req still high in the following IDLE is a new request.
- if_clear=1 during IF_RD:
  - The fetch is aborted at the next edge, going straight to IDLE.
  - No if_done is issued and the partial word is discarded.
  - if_clear in IDLE blocks that cycle's IF accept.
- if_clear never affects MEM_RD or MEM_WR.
- Address arithmetic wraps modulo 2^ADDR_WIDTH.
- Outside write cycles ram_wr=0; ram_a holds its last value.

Optional Feature:
- IO_FULL_STALL_EN.
- Defined:
  - Adds input io_buffer_full (1 bit).
  - In MEM_WR, a byte whose address has bits [17:16]=2'b11 is not driven (ram_wr=0) while io_buffer_full=1. The byte counter holds and the byte issues on the first cycle with io_buffer_full=0.
  - mem_done is delayed by the stall count.
- Undefined: port absent; writes never stall.

Test Plan:
- Reset mid-transfer: assert rst=0 during MEM_WR byte 2 → all outputs 0 immediately, and after release state=IDLE with no done pulse.
- IF word read: if_addr=0x100, RAM bytes 0x13,0x05,0x10,0x00 → ram_a 0x100..0x103 in cycles 1-4, if_done in cycle 6 with if_data=0x00100513.
- Simultaneous requests: if_req and mem_req (load, len=1, addr=0x2002) in the same cycle → MEM served first, with mem_done in cycle 4 and mem_rdata=0x0000xxyy zero-extended. IF is accepted the cycle after DONE.
- Store word: mem_wdata=0xDEADBEEF, addr=0x3FFFC → ram_wr=1 for 4 cycles with ram_dout EF,BE,AD,DE; mem_done in cycle 5.
- if_clear at cycle 3 of a fetch → no if_done, IDLE next edge, and a new if_addr=0x200 is accepted at the following edge.
- rdy=0 for 3 cycles mid-read → ram_wr=0 and counters frozen; done arrives exactly 3 cycles late with correct data. With IO_FULL_STALL_EN: an IO byte store with io_buffer_full held for 2 cycles delays mem_done by 2 cycles.
